alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 158 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Control sequencer for an ALU with a multi-cycle multiply/divide unit.
// Single-cycle ops decode in EXEC; mult/div hold their strobe for a fixed count, then pulse StoreMD.
module alu_ctrl_seq #(
    parameter int CTRL_W      = 5,
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [CTRL_W-1:0] controlType,
    input  logic              div_zero,
    output logic [1:0]        condType,
    output logic              divOp,
    output logic              multOp,
    output logic [2:0]        ALUOp,
    output logic              orOp,
    output logic              overflowOp,
    output logic [2:0]        SrcOut,
    output logic [1:0]        StoreMD,
    output logic              ALUOutSave,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, EXEC, MD_RUN, MD_DONE} state_t;

    typedef struct packed {
        logic [1:0] cond_type;
        logic       div_op;
        logic       mult_op;
        logic [2:0] alu_op;
        logic       or_op;
        logic       overflow_op;
        logic [2:0] src_out;
        logic [1:0] store_md;
        logic       alu_out_save;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CODE_DIV  = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] CODE_MULT = CTRL_W'(10);

    state_t           state;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] cnt;
    logic             is_div;

    function automatic ctrl_t decode(input logic [CTRL_W-1:0] code);
        ctrl_t c;
        c = '0;
        if (code < CTRL_W'(8)) begin
            c.alu_op       = code[2:0];
            c.src_out      = (code == CTRL_W'(7)) ? 3'b010 : 3'b011;
            c.alu_out_save = 1'b1;
            c.overflow_op  = (code == CTRL_W'(1)) || (code == CTRL_W'(2)) || (code == CTRL_W'(4));
        end else begin
            case (code)
                CTRL_W'(8):  begin c.or_op = 1'b1; c.src_out = 3'b100; c.alu_out_save = 1'b1; end
                CTRL_W'(11): begin c.alu_op = 3'b001; c.src_out = 3'b011; c.alu_out_save = 1'b1; end
                CTRL_W'(12): begin c.src_out = 3'b001; c.alu_out_save = 1'b1; end
                CTRL_W'(13): begin c.src_out = 3'b000; c.alu_out_save = 1'b1; end
                CTRL_W'(14): c.cond_type = 2'b00;
                CTRL_W'(15): c.cond_type = 2'b01;
                CTRL_W'(16): c.cond_type = 2'b10;
                CTRL_W'(17): c.cond_type = 2'b11;
                CTRL_W'(18): begin c.src_out = 3'b110; c.alu_out_save = 1'b1; end
                default:     c = '0;
            endcase
        end
        return c;
    endfunction

    function automatic logic is_illegal(input logic [CTRL_W-1:0] code);
        return code > CTRL_W'(18);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ctrl    <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            err     <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    ctrl <= '0;
                    busy <= 1'b0;
                    if (req) begin
                        busy <= 1'b1;
                        if (controlType == CODE_MULT) begin
                            state        <= MD_RUN;
                            cnt          <= CNT_W'(MULT_CYCLES - 1);
                            is_div       <= 1'b0;
                            ctrl.mult_op <= 1'b1;
                        end else if (controlType == CODE_DIV) begin
                            state       <= MD_RUN;
                            cnt         <= CNT_W'(DIV_CYCLES - 1);
                            is_div      <= 1'b1;
                            ctrl.div_op <= 1'b1;
                        end else begin
                            state   <= EXEC;
                            ctrl    <= decode(controlType);
                            done    <= 1'b1;
                            illegal <= is_illegal(controlType);
                        end
                    end
                end
                EXEC, MD_DONE: begin
                    state <= IDLE;
                    ctrl  <= '0;
                    busy  <= 1'b0;
                end
                MD_RUN: begin
                    // A zero divisor aborts immediately, taking priority over normal completion.
                    if (is_div && div_zero) begin
                        state <= IDLE;
                        ctrl  <= '0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else if (cnt == '0) begin
                        state         <= MD_DONE;
                        ctrl          <= '0;
                        ctrl.store_md <= is_div ? 2'b01 : 2'b10;
                        done          <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ctrl  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign condType   = ctrl.cond_type;
    assign divOp      = ctrl.div_op;
    assign multOp     = ctrl.mult_op;
    assign ALUOp      = ctrl.alu_op;
    assign orOp       = ctrl.or_op;
    assign overflowOp = ctrl.overflow_op;
    assign SrcOut     = ctrl.src_out;
    assign StoreMD    = ctrl.store_md;
    assign ALUOutSave = ctrl.alu_out_save;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, mult/div sequencing, div-by-zero abort, reset, back-to-back.
module tb_alu_ctrl_seq;

    localparam int CTRL_W = 5;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              req = 1'b0;
    logic [CTRL_W-1:0] controlType = '0;
    logic              div_zero = 1'b0;
    logic [1:0]        condType;
    logic              divOp, multOp;
    logic [2:0]        ALUOp;
    logic              orOp, overflowOp;
    logic [2:0]        SrcOut;
    logic [1:0]        StoreMD;
    logic              ALUOutSave, busy, done, illegal, err;

    int total = 0;
    int bad = 0;

    alu_ctrl_seq #(.CTRL_W(CTRL_W), .MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .controlType(controlType), .div_zero(div_zero),
        .condType(condType), .divOp(divOp), .multOp(multOp), .ALUOp(ALUOp), .orOp(orOp),
        .overflowOp(overflowOp), .SrcOut(SrcOut), .StoreMD(StoreMD), .ALUOutSave(ALUOutSave),
        .busy(busy), .done(done), .illegal(illegal), .err(err)
    );

    always #5 clk = ~clk;

    // Field order: cond(2)_div_mult_alu(3)_or_ovf_src(3)_store(2)_save
    logic [14:0] obs;
    logic [3:0]  sts;  // busy_done_illegal_err
    assign obs = {condType, divOp, multOp, ALUOp, orOp, overflowOp, SrcOut, StoreMD, ALUOutSave};
    assign sts = {busy, done, illegal, err};

    localparam logic [14:0] C_MULT  = 15'b00_0_1_000_0_0_000_00_0;
    localparam logic [14:0] C_DIV   = 15'b00_1_0_000_0_0_000_00_0;
    localparam logic [14:0] C_SMULT = 15'b00_0_0_000_0_0_000_10_0;
    localparam logic [14:0] C_SDIV  = 15'b00_0_0_000_0_0_000_01_0;
    localparam logic [14:0] C_CODE0 = 15'b00_0_0_000_0_0_011_00_1;
    localparam logic [14:0] C_CODE2 = 15'b00_0_0_010_0_1_011_00_1;
    localparam logic [14:0] C_CODE3 = 15'b00_0_0_011_0_0_011_00_1;
    localparam logic [14:0] C_CODE5 = 15'b00_0_0_101_0_0_011_00_1;

    typedef struct {
        int          code;
        logic [14:0] e;
        logic        ill;
    } vec_t;

    vec_t vecs [20] = '{
        '{0,  15'b00_0_0_000_0_0_011_00_1, 1'b0},
        '{1,  15'b00_0_0_001_0_1_011_00_1, 1'b0},
        '{2,  15'b00_0_0_010_0_1_011_00_1, 1'b0},
        '{3,  15'b00_0_0_011_0_0_011_00_1, 1'b0},
        '{4,  15'b00_0_0_100_0_1_011_00_1, 1'b0},
        '{5,  15'b00_0_0_101_0_0_011_00_1, 1'b0},
        '{6,  15'b00_0_0_110_0_0_011_00_1, 1'b0},
        '{7,  15'b00_0_0_111_0_0_010_00_1, 1'b0},
        '{8,  15'b00_0_0_000_1_0_100_00_1, 1'b0},
        '{11, 15'b00_0_0_001_0_0_011_00_1, 1'b0},
        '{12, 15'b00_0_0_000_0_0_001_00_1, 1'b0},
        '{13, 15'b00_0_0_000_0_0_000_00_1, 1'b0},
        '{14, 15'b00_0_0_000_0_0_000_00_0, 1'b0},
        '{15, 15'b01_0_0_000_0_0_000_00_0, 1'b0},
        '{16, 15'b10_0_0_000_0_0_000_00_0, 1'b0},
        '{17, 15'b11_0_0_000_0_0_000_00_0, 1'b0},
        '{18, 15'b00_0_0_000_0_0_110_00_1, 1'b0},
        '{19, 15'b00_0_0_000_0_0_000_00_0, 1'b1},
        '{25, 15'b00_0_0_000_0_0_000_00_0, 1'b1},
        '{31, 15'b00_0_0_000_0_0_000_00_0, 1'b1}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        total++; if (obs !== 15'd0) begin bad++; $display("FAIL reset_ctrl: got %h want %h", obs, 15'd0); end
        total++; if (sts !== 4'b0000) begin bad++; $display("FAIL reset_sts: got %b want %b", sts, 4'b0000); end
        @(negedge clk);
        reset_n = 1'b1;
        req = 1'b1;
        controlType = 5'd2;
        tick();
        req = 1'b0;
        total++; if (obs !== C_CODE2) begin bad++; $display("FAIL first_req_ctrl: got %h want %h", obs, C_CODE2); end
        total++; if (sts !== 4'b1100) begin bad++; $display("FAIL first_req_sts: got %b want %b", sts, 4'b1100); end
        tick();
        total++; if (obs !== 15'd0) begin bad++; $display("FAIL first_req_idle_ctrl: got %h want %h", obs, 15'd0); end
        total++; if (sts !== 4'b0000) begin bad++; $display("FAIL first_req_idle_sts: got %b want %b", sts, 4'b0000); end
    endtask

    task automatic test_decode();
        for (int i = 0; i < 20; i++) begin
            req = 1'b1;
            controlType = CTRL_W'(vecs[i].code);
            div_zero = i[0];
            tick();
            req = 1'b0;
            total++;
            if (obs !== vecs[i].e)
                begin bad++; $display("FAIL decode_ctrl code=%0d: got %h want %h", vecs[i].code, obs, vecs[i].e); end
            total++;
            if (sts !== {3'b110, 1'b0} + {2'b00, vecs[i].ill, 1'b0})
                begin bad++; $display("FAIL decode_sts code=%0d: got %b want %b", vecs[i].code, sts, {2'b11, vecs[i].ill, 1'b0}); end
            tick();
            total++;
            if (obs !== 15'd0 || sts !== 4'b0000)
                begin bad++; $display("FAIL decode_idle code=%0d: got %h/%b want 0/0000", vecs[i].code, obs, sts); end
        end
        div_zero = 1'b0;
    endtask

    task automatic test_mult();
        req = 1'b1;
        controlType = 5'd10;
        div_zero = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (obs !== C_MULT) begin bad++; $display("FAIL mult_run%0d_ctrl: got %h want %h", k, obs, C_MULT); end
            total++; if (sts !== 4'b1000) begin bad++; $display("FAIL mult_run%0d_sts: got %b want %b", k, sts, 4'b1000); end
            tick();
        end
        total++; if (obs !== C_SMULT) begin bad++; $display("FAIL mult_done_ctrl: got %h want %h", obs, C_SMULT); end
        total++; if (sts !== 4'b1100) begin bad++; $display("FAIL mult_done_sts: got %b want %b", sts, 4'b1100); end
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL mult_idle: got %h/%b want 0/0000", obs, sts); end
        div_zero = 1'b0;
    endtask

    task automatic test_div_abort();
        req = 1'b1;
        controlType = 5'd9;
        tick();
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) div_zero = 1'b1;
            total++; if (obs !== C_DIV || sts !== 4'b1000) begin bad++; $display("FAIL div_run%0d: got %h/%b want %h/1000", k, obs, sts, C_DIV); end
            tick();
        end
        div_zero = 1'b0;
        total++; if (obs !== 15'd0) begin bad++; $display("FAIL div_abort_ctrl: got %h want %h", obs, 15'd0); end
        total++; if (sts !== 4'b0001) begin bad++; $display("FAIL div_abort_sts: got %b want %b", sts, 4'b0001); end
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL div_abort_after: got %h/%b want 0/0000", obs, sts); end
    endtask

    task automatic test_div_full();
        int n;
        req = 1'b1;
        controlType = 5'd9;
        tick();
        req = 1'b0;
        n = 0;
        while (divOp === 1'b1 && busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n != 32) begin bad++; $display("FAIL div_cycles: got %0d want %0d", n, 32); end
        total++; if (obs !== C_SDIV) begin bad++; $display("FAIL div_done_ctrl: got %h want %h", obs, C_SDIV); end
        total++; if (sts !== 4'b1100) begin bad++; $display("FAIL div_done_sts: got %b want %b", sts, 4'b1100); end
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL div_idle: got %h/%b want 0/0000", obs, sts); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1;
        controlType = 5'd10;
        tick();
        req = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (obs !== 15'd0) begin bad++; $display("FAIL async_rst_ctrl: got %h want %h", obs, 15'd0); end
        total++; if (sts !== 4'b0000) begin bad++; $display("FAIL async_rst_sts: got %b want %b", sts, 4'b0000); end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL post_rst%0d: got %h/%b want 0/0000", k, obs, sts); end
        end
        req = 1'b1;
        controlType = 5'd0;
        tick();
        req = 1'b0;
        total++; if (obs !== C_CODE0 || sts !== 4'b1100) begin bad++; $display("FAIL post_rst_op: got %h/%b want %h/1100", obs, sts, C_CODE0); end
        tick();
    endtask

    task automatic test_back_to_back();
        req = 1'b1;
        controlType = 5'd10;
        tick();
        controlType = 5'd3;
        for (int k = 0; k < 4; k++) begin
            total++; if (obs !== C_MULT || sts !== 4'b1000) begin bad++; $display("FAIL held_run%0d: got %h/%b want %h/1000", k, obs, sts, C_MULT); end
            tick();
        end
        total++; if (obs !== C_SMULT || sts !== 4'b1100) begin bad++; $display("FAIL held_done: got %h/%b want %h/1100", obs, sts, C_SMULT); end
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL held_idle: got %h/%b want 0/0000", obs, sts); end
        tick();
        total++; if (obs !== C_CODE3 || sts !== 4'b1100) begin bad++; $display("FAIL held_accept: got %h/%b want %h/1100", obs, sts, C_CODE3); end
        controlType = 5'd5;
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL b2b_gap: got %h/%b want 0/0000", obs, sts); end
        tick();
        req = 1'b0;
        total++; if (obs !== C_CODE5 || sts !== 4'b1100) begin bad++; $display("FAIL b2b_second: got %h/%b want %h/1100", obs, sts, C_CODE5); end
        tick();
        total++; if (obs !== 15'd0 || sts !== 4'b0000) begin bad++; $display("FAIL b2b_end: got %h/%b want 0/0000", obs, sts); end
    endtask

    initial begin
        #1;
        test_reset();
        test_decode();
        test_mult();
        test_div_abort();
        test_div_full();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
